// File: rtl/CONF_item_pack.sv
`default_nettype none
// ============================================================================
// Package     : CONF_item_pack
// Description : Shared widths and types for the CONF configuration port and
//               the arbiter that multiplexes requesters onto it.
//               c_addr_WIDTH  - CONF address width
//               c_data_WIDTH  - CONF data width
//               conf_arb_state_t - arbiter FSM state
// Revision    : 1.0 - initial release
// ============================================================================
package CONF_item_pack;

   localparam int c_addr_WIDTH = 16;
   localparam int c_data_WIDTH = 32;

   typedef enum logic [0:0] {
      CONF_ARB_IDLE = 1'b0,
      CONF_ARB_SEND = 1'b1
   } conf_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/conf_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : conf_rr_pick
// Description : Combinational round-robin picker. Returns the first set bit
//               of req, searching upward from rr_ptr and wrapping modulo
//               N_REQ (works for non-power-of-2 N_REQ).
// Ports       : req     in  N_REQ          request vector
//               rr_ptr  in  clog2(N_REQ)   search start index (< N_REQ)
//               grant   out clog2(N_REQ)   selected index (0 when no request)
//               any_req out 1              at least one request bit set
// Revision    : 1.0 - initial release
// ============================================================================
module conf_rr_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] rr_ptr,
   output logic [$clog2(N_REQ)-1:0] grant,
   output logic                     any_req
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CND_W = IDX_W + 1;

   // One extra bit so rr_ptr + offset cannot overflow before the wrap.
   logic [CND_W-1:0] cand;

   // Walk offsets from the far end down to 0 so the last hit, which is the
   // one that sticks, is the candidate closest to rr_ptr.
   always_comb begin
      grant   = '0;
      cand    = '0;
      any_req = |req;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         cand = {1'b0, rr_ptr} + CND_W'(i);
         if (cand >= CND_W'(N_REQ)) begin
            cand = cand - CND_W'(N_REQ);
         end
         if (req[cand[IDX_W-1:0]]) begin
            grant = cand[IDX_W-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/conf_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : conf_arbiter
// Description : Shares one CONF write port between N_REQ requesters with
//               round-robin arbitration and one outstanding write. The
//               captured write is held on c_addr/c_data/c_valid until
//               c_ready; an optional timeout aborts a write never accepted.
// Ports       : clk        in  1                 clock, posedge
//               rst_n      in  1                 async active-low reset
//               req_valid  in  N_REQ             per-requester write pending
//               req_addr   in  N_REQ*addr width  packed, slice i = req i
//               req_data   in  N_REQ*data width  packed, slice i = req i
//               req_ready  out N_REQ             completion pulse to grantee
//               req_err    out N_REQ             timeout flag with req_ready
//               c_addr     out addr width        CONF address (registered)
//               c_data     out data width        CONF data (registered)
//               c_valid    out 1                 CONF write valid (registered)
//               c_ready    in  1                 CONF slave accepts the write
//               busy       out 1                 write in flight
//               grant_id   out clog2(N_REQ)      current / last grantee
// Revision    : 1.0 - initial release
// ============================================================================
module conf_arbiter
   import CONF_item_pack::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 256
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [N_REQ-1:0]                 req_valid,
   input  logic [N_REQ*c_addr_WIDTH-1:0]    req_addr,
   input  logic [N_REQ*c_data_WIDTH-1:0]    req_data,
   output logic [N_REQ-1:0]                 req_ready,
   output logic [N_REQ-1:0]                 req_err,
   output logic [c_addr_WIDTH-1:0]          c_addr,
   output logic [c_data_WIDTH-1:0]          c_data,
   output logic                             c_valid,
   input  logic                             c_ready,
   output logic                             busy,
   output logic [$clog2(N_REQ)-1:0]         grant_id
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;
   localparam bit TO_EN = (TIMEOUT > 0);
   // Last SEND cycle index before the write is abandoned.
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   conf_arb_state_t          state_q, state_d;
   logic [c_addr_WIDTH-1:0]  c_addr_q, c_addr_d;
   logic [c_data_WIDTH-1:0]  c_data_q, c_data_d;
   logic                     c_valid_q, c_valid_d;
   logic [IDX_W-1:0]         grant_q, grant_d;
   logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;

   logic [IDX_W-1:0]         pick;
   logic                     any_req;
   logic                     in_send;
   logic                     xfer;
   logic                     tmo;
   logic                     done;

   conf_rr_pick #(
      .N_REQ   (N_REQ)
   ) u_pick (
      .req     (req_valid),
      .rr_ptr  (rr_ptr_q),
      .grant   (pick),
      .any_req (any_req)
   );

   assign in_send = (state_q == CONF_ARB_SEND);
   assign xfer    = in_send && c_valid_q && c_ready;
   // A c_ready on the final cycle is a real transfer, so it masks the timeout.
   assign tmo     = TO_EN && in_send && !c_ready && (cnt_q == TO_LAST);
   assign done    = xfer || tmo;

   // Completion pulses are combinational so the requester sees them in the
   // same cycle the CONF slave accepts the write.
   always_comb begin
      req_ready = '0;
      req_err   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = done && (grant_q == IDX_W'(i));
         req_err[i]   = tmo  && (grant_q == IDX_W'(i));
      end
   end

   always_comb begin
      state_d   = state_q;
      c_addr_d  = c_addr_q;
      c_data_d  = c_data_q;
      c_valid_d = c_valid_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      cnt_d     = cnt_q;
      case (state_q)
         CONF_ARB_IDLE: begin
            if (any_req) begin
               c_addr_d  = req_addr[int'(pick) * c_addr_WIDTH +: c_addr_WIDTH];
               c_data_d  = req_data[int'(pick) * c_data_WIDTH +: c_data_WIDTH];
               c_valid_d = 1'b1;
               grant_d   = pick;
               cnt_d     = '0;
               state_d   = CONF_ARB_SEND;
            end
         end
         CONF_ARB_SEND: begin
            if (done) begin
               c_valid_d = 1'b0;
               // Next search starts just past the grantee; explicit wrap
               // keeps non-power-of-2 N_REQ in range.
               rr_ptr_d  = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
               cnt_d     = '0;
               state_d   = CONF_ARB_IDLE;
            end else if (TO_EN) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d   = CONF_ARB_IDLE;
            c_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= CONF_ARB_IDLE;
         c_addr_q  <= '0;
         c_data_q  <= '0;
         c_valid_q <= 1'b0;
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         c_addr_q  <= c_addr_d;
         c_data_q  <= c_data_d;
         c_valid_q <= c_valid_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   assign c_addr   = c_addr_q;
   assign c_data   = c_data_q;
   assign c_valid  = c_valid_q;
   assign busy     = in_send;
   assign grant_id = grant_q;

endmodule
`default_nettype wire
